// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared opcodes, instruction-type encodings and decoded control struct
package id_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ITYPE_NONE  = 5'b00000;
    localparam logic [4:0] ITYPE_ARITH = 5'b10000;
    localparam logic [4:0] ITYPE_LOGIC = 5'b01000;
    localparam logic [4:0] ITYPE_LDST  = 5'b00100;
    localparam logic [4:0] ITYPE_JUMP  = 5'b00010;

    // Width-independent part of the decoded packet; data fields follow DATA_WIDTH.
    typedef struct packed {
        logic       illegal;
        logic       alt_op;
        logic [4:0] inst_type;
        logic [7:0] inst_opcode;
    } id_ctrl_t;

    // add/sub, slt, sltu are arithmetic; everything else in OP/OP-IMM is logic/shift.
    function automatic logic [4:0] alu_type(input logic [2:0] funct3);
        case (funct3)
            3'b000, 3'b010, 3'b011: return ITYPE_ARITH;
            default:                return ITYPE_LOGIC;
        endcase
    endfunction

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational RV64I decoder producing the next pipeline packet
module id_decode
    import id_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  in_valid,
    input  logic [31:0]           inst,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  rs1_r_ena,
    output logic [REG_ADDR_W-1:0] rs1_r_addr,
    output logic                  rs2_r_ena,
    output logic [REG_ADDR_W-1:0] rs2_r_addr,
    output logic                  rd_w_ena,
    output logic [REG_ADDR_W-1:0] rd_w_addr,
    output id_ctrl_t              ctrl,
    output logic [DATA_WIDTH-1:0] op1,
    output logic [DATA_WIDTH-1:0] op2,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [DATA_WIDTH-1:0] store_data
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] f3_eff;
    logic       legal;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
    logic       alt;
    logic [4:0] itype;

    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] imm_j;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    assign imm_i = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(DATA_WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(DATA_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{(DATA_WIDTH-32){inst[31]}}, inst[31:12], 12'b0};
    assign imm_j = {{(DATA_WIDTH-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Per-opcode legality, register usage, operand selection; illegal squashes everything.
    always_comb begin
        legal      = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd     = 1'b0;
        alt        = 1'b0;
        itype      = ITYPE_NONE;
        f3_eff     = f3;
        imm        = '0;
        op1        = '0;
        op2        = '0;
        store_data = '0;
        case (opc)
            OPC_LUI: begin
                legal = 1'b1; use_rd = 1'b1; f3_eff = 3'b000; itype = ITYPE_ARITH;
                imm = imm_u; op2 = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1; use_rd = 1'b1; f3_eff = 3'b000; itype = ITYPE_ARITH;
                imm = imm_u; op1 = pc; op2 = imm_u;
            end
            OPC_JAL: begin
                legal = 1'b1; use_rd = 1'b1; f3_eff = 3'b000; itype = ITYPE_JUMP;
                imm = imm_j; op1 = pc; op2 = DATA_WIDTH'(4);
            end
            OPC_JALR: begin
                legal = (f3 == 3'b000); use_rs1 = 1'b1; use_rd = 1'b1; itype = ITYPE_JUMP;
                imm = imm_i; op1 = pc; op2 = DATA_WIDTH'(4);
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                use_rs1 = 1'b1; use_rs2 = 1'b1; itype = ITYPE_JUMP;
                imm = imm_b; op1 = rs1_data; op2 = rs2_data;
            end
            OPC_LOAD: begin
                legal = (f3 != 3'b111); use_rs1 = 1'b1; use_rd = 1'b1; itype = ITYPE_LDST;
                imm = imm_i; op1 = rs1_data; op2 = imm_i;
            end
            OPC_STORE: begin
                legal = !f3[2]; use_rs1 = 1'b1; use_rs2 = 1'b1; itype = ITYPE_LDST;
                imm = imm_s; op1 = rs1_data; op2 = imm_s; store_data = rs2_data;
            end
            OPC_OPIMM: begin
                case (f3)
                    3'b001:  legal = (inst[31:26] == 6'b000000);
                    3'b101:  legal = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
                    default: legal = 1'b1;
                endcase
                use_rs1 = 1'b1; use_rd = 1'b1; itype = alu_type(f3);
                alt = (f3 == 3'b101) ? inst[30] : 1'b0;
                imm = imm_i; op1 = rs1_data; op2 = imm_i;
            end
            OPC_OP: begin
                legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; itype = alu_type(f3);
                alt = inst[30];
                op1 = rs1_data; op2 = rs2_data;
            end
            default: ;
        endcase
        if (!legal) begin
            use_rs1    = 1'b0;
            use_rs2    = 1'b0;
            use_rd     = 1'b0;
            alt        = 1'b0;
            itype      = ITYPE_NONE;
            imm        = '0;
            op1        = '0;
            op2        = '0;
            store_data = '0;
        end
    end

    assign rs1_r_ena  = in_valid && use_rs1;
    assign rs2_r_ena  = in_valid && use_rs2;
    assign rs1_r_addr = rs1_r_ena ? REG_ADDR_W'(inst[19:15]) : '0;
    assign rs2_r_addr = rs2_r_ena ? REG_ADDR_W'(inst[24:20]) : '0;
    assign rd_w_ena   = use_rd && (inst[11:7] != 5'd0);
    assign rd_w_addr  = rd_w_ena ? REG_ADDR_W'(inst[11:7]) : '0;

    assign ctrl.illegal     = !legal;
    assign ctrl.alt_op      = alt;
    assign ctrl.inst_type   = itype;
    assign ctrl.inst_opcode = {f3_eff, inst[6:2]};

endmodule

// File: rtl/id_pipe_stage.sv
// rtl/id_pipe_stage.sv - decode stage with handshake and pipeline register; ID_FWD_EN adds forwarding
module id_pipe_stage
    import id_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef ID_FWD_EN
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    input  logic [DATA_WIDTH-1:0] fwd_data,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           inst,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  rs1_r_ena,
    output logic [REG_ADDR_W-1:0] rs1_r_addr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    output logic                  rs2_r_ena,
    output logic [REG_ADDR_W-1:0] rs2_r_addr,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  rd_w_ena,
    output logic [REG_ADDR_W-1:0] rd_w_addr,
    output logic [4:0]            inst_type,
    output logic [7:0]            inst_opcode,
    output logic                  alt_op,
    output logic [DATA_WIDTH-1:0] op1,
    output logic [DATA_WIDTH-1:0] op2,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic                  illegal
);

    logic [DATA_WIDTH-1:0] rs1_eff;
    logic [DATA_WIDTH-1:0] rs2_eff;
    logic                  dec_rd_w_ena;
    logic [REG_ADDR_W-1:0] dec_rd_w_addr;
    id_ctrl_t              dec_ctrl;
    logic [DATA_WIDTH-1:0] dec_op1;
    logic [DATA_WIDTH-1:0] dec_op2;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic [DATA_WIDTH-1:0] dec_store_data;
    logic                  capture;

`ifdef ID_FWD_EN
    assign rs1_eff = (fwd_valid && (fwd_addr == rs1_r_addr) && (fwd_addr != '0)) ? fwd_data : rs1_data;
    assign rs2_eff = (fwd_valid && (fwd_addr == rs2_r_addr) && (fwd_addr != '0)) ? fwd_data : rs2_data;
`else
    assign rs1_eff = rs1_data;
    assign rs2_eff = rs2_data;
`endif

    id_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decode (
        .in_valid   (in_valid),
        .inst       (inst),
        .pc         (pc),
        .rs1_data   (rs1_eff),
        .rs2_data   (rs2_eff),
        .rs1_r_ena  (rs1_r_ena),
        .rs1_r_addr (rs1_r_addr),
        .rs2_r_ena  (rs2_r_ena),
        .rs2_r_addr (rs2_r_addr),
        .rd_w_ena   (dec_rd_w_ena),
        .rd_w_addr  (dec_rd_w_addr),
        .ctrl       (dec_ctrl),
        .op1        (dec_op1),
        .op2        (dec_op2),
        .imm        (dec_imm),
        .store_data (dec_store_data)
    );

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    // Single-entry pipeline register: flush beats capture, capture beats drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            rd_w_ena    <= 1'b0;
            rd_w_addr   <= '0;
            inst_type   <= '0;
            inst_opcode <= '0;
            alt_op      <= 1'b0;
            op1         <= '0;
            op2         <= '0;
            imm         <= '0;
            store_data  <= '0;
            pc_out      <= '0;
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            rd_w_ena    <= dec_rd_w_ena;
            rd_w_addr   <= dec_rd_w_addr;
            inst_type   <= dec_ctrl.inst_type;
            inst_opcode <= dec_ctrl.inst_opcode;
            alt_op      <= dec_ctrl.alt_op;
            op1         <= dec_op1;
            op2         <= dec_op2;
            imm         <= dec_imm;
            store_data  <= dec_store_data;
            pc_out      <= pc;
            illegal     <= dec_ctrl.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// tb/tb_id_pipe_stage.sv - scoreboard bench for id_pipe_stage with directed RV64I vectors
module tb_id_pipe_stage;

    localparam int DW = 64;
    localparam int AW = 5;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        rd_ena;
        logic [4:0]  rd;
        logic [4:0]  ty;
        logic [7:0]  opc;
        logic        alt;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] imm;
        logic [63:0] sd;
        logic        ill;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   inst = '0;
    logic [DW-1:0] pc = '0;
    logic          rs1_r_ena;
    logic [AW-1:0] rs1_r_addr;
    logic [DW-1:0] rs1_data = '0;
    logic          rs2_r_ena;
    logic [AW-1:0] rs2_r_addr;
    logic [DW-1:0] rs2_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          rd_w_ena;
    logic [AW-1:0] rd_w_addr;
    logic [4:0]    inst_type;
    logic [7:0]    inst_opcode;
    logic          alt_op;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] imm;
    logic [DW-1:0] store_data;
    logic [DW-1:0] pc_out;
    logic          illegal;
`ifdef ID_FWD_EN
    logic          fwd_valid = 1'b0;
    logic [AW-1:0] fwd_addr = '0;
    logic [DW-1:0] fwd_data = '0;
`endif

    vec_t vecs[10];
    vec_t exp_q[$];
    vec_t mon_e;
    vec_t fv;
    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;
    int   pops = 0;

    id_pipe_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef ID_FWD_EN
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inst        (inst),
        .pc          (pc),
        .rs1_r_ena   (rs1_r_ena),
        .rs1_r_addr  (rs1_r_addr),
        .rs1_data    (rs1_data),
        .rs2_r_ena   (rs2_r_ena),
        .rs2_r_addr  (rs2_r_addr),
        .rs2_data    (rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rd_w_ena    (rd_w_ena),
        .rd_w_addr   (rd_w_addr),
        .inst_type   (inst_type),
        .inst_opcode (inst_opcode),
        .alt_op      (alt_op),
        .op1         (op1),
        .op2         (op2),
        .imm         (imm),
        .store_data  (store_data),
        .pc_out      (pc_out),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] inst_i, input logic [63:0] pc_i, rs1_i, rs2_i,
                                input logic rd_ena_i, input logic [4:0] rd_i, ty_i,
                                input logic [7:0] opc_i, input logic alt_i,
                                input logic [63:0] op1_i, op2_i, imm_i, sd_i, input logic ill_i);
        vec_t v;
        v.inst = inst_i; v.pc = pc_i; v.rs1 = rs1_i; v.rs2 = rs2_i;
        v.rd_ena = rd_ena_i; v.rd = rd_i; v.ty = ty_i; v.opc = opc_i; v.alt = alt_i;
        v.op1 = op1_i; v.op2 = op2_i; v.imm = imm_i; v.sd = sd_i; v.ill = ill_i;
        return v;
    endfunction

    // Present one instruction and hold it until accepted; push its expectation when accepted.
    task automatic issue(input vec_t v, input bit push);
        bit done = 1'b0;
        inst = v.inst; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2; in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) begin
                    exp_q.push_back(v);
                    pushes++;
                end
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("issue_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // Monitor: every accepted output packet must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                pops++;
                check("rd_w_ena",    64'(rd_w_ena),    64'(mon_e.rd_ena));
                check("rd_w_addr",   64'(rd_w_addr),   64'(mon_e.rd));
                check("inst_type",   64'(inst_type),   64'(mon_e.ty));
                check("inst_opcode", 64'(inst_opcode), 64'(mon_e.opc));
                check("alt_op",      64'(alt_op),      64'(mon_e.alt));
                check("op1",         op1,              mon_e.op1);
                check("op2",         op2,              mon_e.op2);
                check("imm",         imm,              mon_e.imm);
                check("store_data",  store_data,       mon_e.sd);
                check("pc_out",      pc_out,           mon_e.pc);
                check("illegal",     64'(illegal),     64'(mon_e.ill));
            end
        end
    end

    initial begin
        vecs[0] = mk(32'hFFF08293, 64'h1000, 64'd10, 64'd0, 1'b1, 5'd5, 5'b10000, 8'h04, 1'b0,
                     64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        vecs[1] = mk(32'h402081B3, 64'h1004, 64'd100, 64'd30, 1'b1, 5'd3, 5'b10000, 8'h0C, 1'b1,
                     64'd100, 64'd30, 64'd0, 64'd0, 1'b0);
        vecs[2] = mk(32'h00000000, 64'h1008, 64'h11, 64'h22, 1'b0, 5'd0, 5'b00000, 8'h00, 1'b0,
                     64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        vecs[3] = mk(32'h00000013, 64'h100C, 64'd0, 64'd0, 1'b0, 5'd0, 5'b10000, 8'h04, 1'b0,
                     64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        vecs[4] = mk(32'h800003B7, 64'h1010, 64'h33, 64'h44, 1'b1, 5'd7, 5'b10000, 8'h0D, 1'b0,
                     64'd0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0);
        vecs[5] = mk(32'h0020A423, 64'h1014, 64'h2000, 64'hDEAD, 1'b0, 5'd0, 5'b00100, 8'h48, 1'b0,
                     64'h2000, 64'd8, 64'd8, 64'hDEAD, 1'b0);
        vecs[6] = mk(32'hFE208EE3, 64'h1018, 64'd5, 64'd6, 1'b0, 5'd0, 5'b00010, 8'h18, 1'b0,
                     64'd5, 64'd6, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0);
        vecs[7] = mk(32'h010000EF, 64'h101C, 64'd0, 64'd0, 1'b1, 5'd1, 5'b00010, 8'h1B, 1'b0,
                     64'h101C, 64'd4, 64'd16, 64'd0, 1'b0);
        vecs[8] = mk(32'h4051D213, 64'h1020, 64'h80, 64'd0, 1'b1, 5'd4, 5'b01000, 8'hA4, 1'b1,
                     64'h80, 64'h405, 64'h405, 64'd0, 1'b0);
        vecs[9] = mk(32'h02208133, 64'h1024, 64'd1, 64'd2, 1'b0, 5'd0, 5'b00000, 8'h0C, 1'b0,
                     64'd0, 64'd0, 64'd0, 64'd0, 1'b1);

        // Reset state, with an instruction offered that must not be captured.
        inst = vecs[0].inst; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_op1",       op1,            64'd0);
        check("reset_rd_w_ena",  64'(rd_w_ena),  64'd0);
        check("reset_inst_type", 64'(inst_type), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_out_valid", 64'(out_valid), 64'd0);

        // Register-read ports for sub x3,x1,x2 while it is presented.
        inst = vecs[1].inst; in_valid = 1'b1; #1;
        check("sub_rs1_r_ena",  64'(rs1_r_ena),  64'd1);
        check("sub_rs2_r_ena",  64'(rs2_r_ena),  64'd1);
        check("sub_rs1_r_addr", 64'(rs1_r_addr), 64'd1);
        check("sub_rs2_r_addr", 64'(rs2_r_addr), 64'd2);
        in_valid = 1'b0; #1;
        check("idle_rs1_r_ena", 64'(rs1_r_ena), 64'd0);
        inst = vecs[4].inst; in_valid = 1'b1; #1;
        check("lui_rs1_r_ena",  64'(rs1_r_ena),  64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Back-to-back stream with the consumer always ready.
        for (int i = 0; i < 10; i++) issue(vecs[i], 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Stall: consumer not ready for 3 cycles while a second instruction waits.
        out_ready = 1'b0;
        issue(vecs[0], 1'b1);
        inst = vecs[1].inst; pc = vecs[1].pc; rs1_data = vecs[1].rs1; rs2_data = vecs[1].rs2;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready",  64'(in_ready),  64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_op1",       op1,            64'd10);
            check("stall_pc_out",    pc_out,         64'h1000);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue(vecs[1], 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Flush with an incoming instruction and an empty register: nothing captured.
        inst = vecs[4].inst; pc = vecs[4].pc; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check("flush_in_out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("flush_in_no_late", 64'(out_valid), 64'd0);

        // Flush discards a held packet.
        out_ready = 1'b0;
        issue(vecs[5], 1'b0);
        check("held_out_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush_held_out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;

        // Asynchronous reset mid-cycle discards a held packet.
        issue(vecs[6], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_op1",       op1,            64'd0);
        check("async_rst_pc_out",    pc_out,         64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("after_rst_out_valid", 64'(out_valid), 64'd0);
        issue(vecs[7], 1'b1);

`ifdef ID_FWD_EN
        // Forwarding onto rs1 of addi x5,x1,1; address 0 never forwards.
        fv = mk(32'h00108293, 64'h2000, 64'h77, 64'd0, 1'b1, 5'd5, 5'b10000, 8'h04, 1'b0,
                64'h55, 64'd1, 64'd1, 64'd0, 1'b0);
        fwd_valid = 1'b1; fwd_addr = 5'd1; fwd_data = 64'h55;
        issue(fv, 1'b1);
        fv.op1 = 64'h77;
        fwd_addr = 5'd0;
        issue(fv, 1'b1);
        fwd_valid = 1'b0;
`endif

        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("scoreboard_pops",  64'(pops),         64'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
